// File: rtl/param_loader.sv
// Host-side transmitter for the neuron parameter shift chain: takes bytes over
// valid/ready and shifts them out MSB-first, strobing setup once per bit.
module param_loader #(
  parameter int CHAIN_BITS = 88,
  parameter int CNT_BITS   = $clog2(CHAIN_BITS + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       setup,
  output logic       param_bit,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  // Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
  // in_ready is high only in FETCH; in_data must be stable while in_valid is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(CHAIN_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  state_t              state;
  logic [7:0]          shreg;
  logic [2:0]          bit_cnt;
  logic [CNT_BITS-1:0] total_cnt;
  logic                chain_end;
  logic                byte_end;

  // chain_end also covers the partial final byte: its unused low bits are dropped.
  assign chain_end = (total_cnt == LAST_IDX);
  assign byte_end  = (bit_cnt == 3'd7) || chain_end;
  assign state_dbg = state;

  // Outputs are registered alongside the state so they change only with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      total_cnt <= '0;
      in_ready  <= 1'b0;
      setup     <= 1'b0;
      param_bit <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            total_cnt <= '0;
            state     <= FETCH;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (in_valid && in_ready) begin
            shreg     <= in_data;
            bit_cnt   <= '0;
            state     <= SHIFT;
            in_ready  <= 1'b0;
            setup     <= 1'b1;
            param_bit <= in_data[7];
          end
        end
        SHIFT: begin
          shreg     <= {shreg[6:0], 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
          total_cnt <= total_cnt + CNT_ONE;
          param_bit <= shreg[6];
          if (byte_end) begin
            setup     <= 1'b0;
            param_bit <= 1'b0;
            if (chain_end) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= FETCH;
              in_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          setup     <= 1'b0;
          param_bit <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_loader.sv
// Bench for param_loader: three instances (11, 88 and 9 chain bits) driven from
// a table of load vectors plus hand-written reset, abort and start-ignore sequences.
module tb_param_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start    [3];
  logic [7:0] in_data  [3];
  logic       in_valid [3];
  logic       in_ready_o [3];
  logic       setup_o    [3];
  logic       pbit_o     [3];
  logic       busy_o     [3];
  logic       done_o     [3];
  logic [1:0] st_o       [3];

  param_loader #(.CHAIN_BITS(11)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready_o[0]), .setup(setup_o[0]), .param_bit(pbit_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .state_dbg(st_o[0]));
  param_loader #(.CHAIN_BITS(88)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready_o[1]), .setup(setup_o[1]), .param_bit(pbit_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .state_dbg(st_o[1]));
  param_loader #(.CHAIN_BITS(9)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready_o[2]), .setup(setup_o[2]), .param_bit(pbit_o[2]), .busy(busy_o[2]),
    .done(done_o[2]), .state_dbg(st_o[2]));

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- chain model / monitor ----------------
  // Each instance's chain is a shift register fed by param_bit on every setup cycle.
  int          setup_cnt  [3] = '{0, 0, 0};
  int          done_cnt   [3] = '{0, 0, 0};
  int          glitch_cnt [3] = '{0, 0, 0};
  logic [87:0] chain      [3] = '{default: '0};
  int          chain_len  [3] = '{11, 88, 9};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (setup_o[k]) begin
        setup_cnt[k]++;
        chain[k] = {chain[k][86:0], pbit_o[k]};
      end
      if (done_o[k]) done_cnt[k]++;
      if ((!setup_o[k] && pbit_o[k]) || (setup_o[k] && (in_ready_o[k] || !busy_o[k])))
        glitch_cnt[k]++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          dut;
    int          nbytes;
    logic [87:0] data;       // byte i at data[87-8*i -: 8]
    int          stall_at;   // byte index preceded by a stall, -1 for none
    int          stall_len;
    bit          poke;       // pulse start while shifting
    int          exp_setup;
    logic [87:0] exp_chain;
    int          exp_delta;  // cycles from entering FETCH to the done cycle
  } vec_t;

  vec_t vecs [7];

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input string tag);
    int          k;
    int          s0, d0, g0, t_fetch, t_done, n;
    bit          hs, seen;
    logic [87:0] m;
    k  = v.dut;
    s0 = setup_cnt[k];
    d0 = done_cnt[k];
    g0 = glitch_cnt[k];
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    t_fetch = cyc;
    for (int b = 0; b < v.nbytes; b++) begin
      if (b == v.stall_at) begin
        in_valid[k] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready_o[k] && n < 100);
        for (int s = 0; s < v.stall_len; s++) begin
          if (s > 0) @(negedge clk);
          check({tag, " stall_hold"}, {86'b0, in_ready_o[k], setup_o[k]}, 88'b10);
        end
        @(posedge clk); #1;
      end
      in_data[k]  = v.data[87-8*b -: 8];
      in_valid[k] = 1'b1;
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 200) begin
        @(negedge clk);
        hs = in_ready_o[k] && in_valid[k];
        @(posedge clk); #1;
        n++;
        if (v.poke && b > 0) start[k] = !hs;
      end
      check({tag, " handshake"}, hs, 1);
      if (!hs) begin
        in_valid[k] = 1'b0;
        start[k]    = 1'b0;
        return;
      end
    end
    in_valid[k] = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      seen = done_o[k];
      n++;
    end
    t_done = cyc;
    check({tag, " done_seen"}, seen, 1);
    @(negedge clk);
    check({tag, " busy_after_done"}, busy_o[k], 0);
    repeat (3) @(posedge clk);
    #1;
    m = '1;
    m = m >> (88 - chain_len[k]);
    check({tag, " setup_count"}, setup_cnt[k] - s0, v.exp_setup);
    check({tag, " done_count"}, done_cnt[k] - d0, 1);
    check({tag, " chain"}, chain[k] & m, v.exp_chain);
    check({tag, " load_time"}, t_done - t_fetch, v.exp_delta);
    check({tag, " glitches"}, glitch_cnt[k] - g0, 0);
    check({tag, " idle_after"}, st_o[k], 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int   bits, n;
    logic [87:0] rnd;

    vecs[0] = '{0, 2, {8'hA5, 8'hE0, 72'h0}, -1, 0, 1'b0, 11, 88'h52F, 13};
    vecs[1] = '{0, 2, {8'hA5, 8'hE0, 72'h0},  1, 5, 1'b0, 11, 88'h52F, 18};
    vecs[2] = '{1, 11, 88'h3C91E705D26AB84F17C37E, -1, 0, 1'b0, 88, 88'h3C91E705D26AB84F17C37E, 99};
    rnd = '0;
    for (int i = 0; i < 11; i++) rnd = {rnd[79:0], 8'($urandom_range(0, 255))};
    vecs[3] = '{1, 11, rnd, -1, 0, 1'b0, 88, rnd, 99};
    vecs[4] = '{2, 2, {8'hFF, 8'h80, 72'h0}, -1, 0, 1'b0, 9, 88'h1FF, 11};
    vecs[5] = '{2, 2, {8'h5A, 8'hC1, 72'h0},  1, 3, 1'b0, 9, 88'h0B5, 14};
    vecs[6] = '{0, 2, {8'h3C, 8'h7F, 72'h0}, -1, 0, 1'b1, 11, 88'h1E3, 13};

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k]    = 1'b0;
      in_data[k]  = 8'h00;
      in_valid[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", busy_o[k], 0);
      check("reset_in_ready", in_ready_o[k], 0);
    end

    // async reset while clock is idle mid-cycle
    start[0] = 1'b1;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    check("fetch_ready", in_ready_o[0], 1);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++)
      check("async_reset_outputs",
            {83'b0, in_ready_o[k], setup_o[k], pbit_o[k], busy_o[k], done_o[k]}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_busy", busy_o[0], 0);
    check("post_reset_ready", in_ready_o[0], 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort a full-chain load after 20 bits, then reload from scratch
    @(posedge clk); #1 start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    in_data[1]  = 8'hC3;
    in_valid[1] = 1'b1;
    bits = 0;
    n    = 0;
    while (bits < 20 && n < 200) begin
      @(negedge clk);
      if (setup_o[1]) bits++;
      n++;
    end
    check("abort_bits", bits, 20);
    check("abort_setup_before", setup_o[1], 1);
    #2 reset = 1'b1;
    #1;
    check("abort_setup", setup_o[1], 0);
    check("abort_state", st_o[1], 0);
    check("abort_busy", busy_o[1], 0);
    in_valid[1] = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    run_vec(vecs[2], "reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_loader.md
Name: param_loader

Overview:
- Host-side transmitter for the neuron parameter shift chain.
- Accepts parameter bytes over a valid/ready handshake and serializes them MSB-first onto the chain's serial input.
- Drives the chain's `setup` strobe for exactly one cycle per transmitted bit, so the chain shifts only when a valid bit is present.
- Sits between the host/SPI byte interface and the first neuron's `param_in`. It asserts `done` when all CHAIN_BITS bits have been delivered.

Parameters:
- CHAIN_BITS, 88, total bits in the chain (sum of INPUTS+BIAS_BITS over all neurons; 88 = 8 neurons x 11 bits); must be >= 1.
- CNT_BITS, $clog2(CHAIN_BITS+1), width of the total-bit counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- in_data  input  8  parameter byte; bit 7 is transmitted first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle; handshake = in_valid & in_ready.
- setup  output  1  chain shift enable; high only in SHIFT.
- param_bit  output  1  serial data to the first neuron's param_in; valid whenever setup=1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final bit has been shifted.

Behaviour:
- Reset (async): state=IDLE. in_ready=0, setup=0, param_bit=0, busy=0, done=0. Shift register and counters cleared.
- Reset mid-load aborts immediately and leaves chain contents undefined; a new start is required.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - All outputs 0.
  - On start=1: clear total_cnt and go to FETCH next cycle.
  - start is ignored in all other states.
- FETCH:
  - busy=1, in_ready=1, setup=0.
  - On handshake: capture in_data into an 8-bit shift register, clear bit_cnt, go to SHIFT.
  - Without handshake: stay in FETCH. The chain is held, with no time limit.
- SHIFT:
  - busy=1, setup=1, in_ready=0, param_bit=shreg[7].
  - Each cycle: shift shreg left by one, increment bit_cnt and total_cnt.
  - Leave when the bit just sent is bit_cnt==7 OR total_cnt+1==CHAIN_BITS.
  - Next state is DONE if total_cnt+1==CHAIN_BITS, else FETCH.
- DONE:
  - done=1 and busy=1 for one cycle, then IDLE.
- Partial final byte:
  - When CHAIN_BITS mod 8 = R != 0, only the R MSBs of the last byte are sent.
  - The remaining low bits are discarded with no extra setup cycles.
- Setup pulse count per load: exactly CHAIN_BITS, never more.
  - setup is never high in FETCH, even if in_valid is high.
- One bubble (FETCH) cycle per byte is required.
  - Full-rate load time = ceil(CHAIN_BITS/8) + CHAIN_BITS cycles from entering FETCH to the last setup cycle.
- Chain mapping:
  - The first bit sent lands deepest: the last neuron's bias MSB.
  - The last bit sent lands in the first neuron's weights[0].
- param_bit is driven 0 outside SHIFT.
- Outputs are registered or derived purely from the state; there is no combinational path from in_valid to setup.

Test Plan:
- Reset defaults: assert reset mid-cycle with clk idle -> all outputs 0 immediately. After release, busy=0 and in_ready=0.
- Single neuron (CHAIN_BITS=11): start, then bytes 0xA5, 0xE0 with in_valid always high. Required response:
  - setup high for exactly 11 cycles, in bursts of 8 and 3 separated by one FETCH cycle.
  - param_bit sequence 1,0,1,0,0,1,0,1,1,1,1.
  - Behavioural neuron model ends with bias=3'b101 and weights=8'b00101111.
  - done pulses once, 13 cycles after entering FETCH.
- Stall: drop in_valid for 5 cycles before the second byte -> in_ready stays high and setup stays 0 for those 5 cycles. Final chain contents are identical to the no-stall case.
- Full chain (CHAIN_BITS=88): send 11 random bytes -> exactly 88 setup cycles. An 8-neuron model matches the byte stream bit-for-bit. busy falls the cycle after done.
- Abort and ignore:
  - Assert reset after 20 bits -> setup drops immediately, state returns to IDLE. A fresh start then loads correctly.
  - start pulses during SHIFT are ignored, giving no extra setup cycles.
- Non-aligned length (CHAIN_BITS=9): bytes 0xFF, 0x80 -> 9 setup cycles with param_bit all 1. The low 7 bits of the second byte are never shifted.
